// File: rtl/index_selector_if.sv
`default_nettype none
// ============================================================================
//  Module      : index_selector_if
//  Description : Bundle of the index selector's button, load and status
//                signals.
//                master : drives btn_up, btn_down, load, load_val;
//                         observes sel, changed, at_min, at_max
//                slave  : the index selector itself
//  Revision    : 1.0  initial release
// ============================================================================
interface index_selector_if #(
    parameter int WIDTH = 3
);
    logic             btn_up;
    logic             btn_down;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] sel;
    logic             changed;
    logic             at_min;
    logic             at_max;

    modport master (
        output btn_up, btn_down, load, load_val,
        input  sel, changed, at_min, at_max
    );

    modport slave (
        input  btn_up, btn_down, load, load_val,
        output sel, changed, at_min, at_max
    );
endinterface
`default_nettype wire

// File: rtl/index_selector.sv
`default_nettype none
// ============================================================================
//  Module      : index_selector
//  Description : Button-driven up/down index with wrap or saturate at the
//                bounds, a load strobe with clamping, and status flags.
//                Each raw button goes through a 2-flop synchronizer and
//                produces one step on the rising edge of its conditioned
//                level.
//                Optional macro INDEX_SELECTOR_DEBOUNCE_EN adds a per-button
//                stability counter of DB_CYCLES clocks ahead of the edge
//                detector; without it the conditioned level is the
//                synchronizer output.
//  Ports       : clk  - clock, all state on rising edge
//                rst  - asynchronous active-high reset
//                bus  - index_selector_if.slave
//                       (btn_up, btn_down, load, load_val in;
//                        sel, changed, at_min, at_max out)
//  Revision    : 1.0  initial release
// ============================================================================
module index_selector #(
    parameter int WIDTH     = 3,
    parameter int MAX_VAL   = 5,
    parameter int WRAP      = 1,
    parameter int DB_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    index_selector_if.slave   bus
);

    localparam logic [WIDTH-1:0] c_max = WIDTH'(MAX_VAL);

    generate
        if ((MAX_VAL < 1) || (MAX_VAL > (2**WIDTH - 1)) || (DB_CYCLES < 1)) begin : g_param_check
            $error("index_selector: illegal MAX_VAL/WIDTH/DB_CYCLES combination");
        end
    endgenerate

    // Bit 0 carries the up button, bit 1 the down button throughout.
    logic [1:0] w_raw;
    logic [1:0] r_s1;
    logic [1:0] r_s2;
    logic [1:0] w_lvl;
    logic [1:0] r_lvl_d;
    logic [1:0] w_step;

    assign w_raw = {bus.btn_down, bus.btn_up};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= w_raw;
            r_s2 <= r_s1;
        end
    end

`ifdef INDEX_SELECTOR_DEBOUNCE_EN
    localparam int                  c_cnt_w   = $clog2(DB_CYCLES + 1);
    localparam logic [c_cnt_w-1:0]  c_db_last = c_cnt_w'(DB_CYCLES - 1);

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_db
            logic [c_cnt_w-1:0] r_cnt;
            logic               r_lvl;

            // The counter only runs while s2 disagrees with the accepted
            // level; any agreement restarts the stability window.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_cnt <= '0;
                    r_lvl <= 1'b0;
                end else if (r_s2[gi] == r_lvl) begin
                    r_cnt <= '0;
                end else if (r_cnt == c_db_last) begin
                    r_lvl <= r_s2[gi];
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end

            assign w_lvl[gi] = r_lvl;
        end
    endgenerate
`else
    assign w_lvl = r_s2;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lvl_d <= '0;
        end else begin
            r_lvl_d <= w_lvl;
        end
    end

    assign w_step = w_lvl & ~r_lvl_d;

    logic [WIDTH-1:0] r_sel;
    logic [WIDTH-1:0] w_sel_nxt;
    logic             r_changed;
    logic             r_at_min;
    logic             r_at_max;

    // Load beats steps; simultaneous up and down steps cancel (w_step 2'b11).
    always_comb begin
        w_sel_nxt = r_sel;
        if (bus.load) begin
            w_sel_nxt = (bus.load_val > c_max) ? c_max : bus.load_val;
        end else if (w_step == 2'b01) begin
            if (r_sel == c_max) begin
                w_sel_nxt = (WRAP != 0) ? '0 : r_sel;
            end else begin
                w_sel_nxt = r_sel + 1'b1;
            end
        end else if (w_step == 2'b10) begin
            if (r_sel == '0) begin
                w_sel_nxt = (WRAP != 0) ? c_max : r_sel;
            end else begin
                w_sel_nxt = r_sel - 1'b1;
            end
        end
    end

    // Flags are computed from the next value so they change on the same
    // edge as sel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sel     <= '0;
            r_changed <= 1'b0;
            r_at_min  <= 1'b1;
            r_at_max  <= 1'b0;
        end else begin
            r_sel     <= w_sel_nxt;
            r_changed <= (w_sel_nxt != r_sel);
            r_at_min  <= (w_sel_nxt == '0);
            r_at_max  <= (w_sel_nxt == c_max);
        end
    end

    assign bus.sel     = r_sel;
    assign bus.changed = r_changed;
    assign bus.at_min  = r_at_min;
    assign bus.at_max  = r_at_max;

endmodule
`default_nettype wire

// File: tb/tb_index_selector.sv
`default_nettype none
// ============================================================================
//  Module      : tb_index_selector
//  Description : Self-checking bench for index_selector. Two instances
//                (wrap and saturate) share one stimulus stream; a
//                behavioural model derives the expected index from the
//                sampled button history and is compared every cycle, with
//                literal expectations for the directed scenarios.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_index_selector;

    localparam int MAXV = 5;
    localparam int DB   = 4;
    localparam int HMAX = 8192;
`ifdef INDEX_SELECTOR_DEBOUNCE_EN
    localparam bit DEB = 1'b1;
    localparam int LAT = 2 + DB;
`else
    localparam bit DEB = 1'b0;
    localparam int LAT = 2;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       up  = 1'b0;
    logic       dn  = 1'b0;
    logic       ld  = 1'b0;
    logic [2:0] ldv = 3'd0;

    always #5 clk = ~clk;

    index_selector_if #(.WIDTH(3)) if_w ();
    index_selector_if #(.WIDTH(3)) if_s ();

    assign if_w.btn_up   = up;
    assign if_w.btn_down = dn;
    assign if_w.load     = ld;
    assign if_w.load_val = ldv;
    assign if_s.btn_up   = up;
    assign if_s.btn_down = dn;
    assign if_s.load     = ld;
    assign if_s.load_val = ldv;

    index_selector #(.WIDTH(3), .MAX_VAL(MAXV), .WRAP(1), .DB_CYCLES(DB)) dut_w (
        .clk (clk),
        .rst (rst),
        .bus (if_w)
    );

    index_selector #(.WIDTH(3), .MAX_VAL(MAXV), .WRAP(0), .DB_CYCLES(DB)) dut_s (
        .clk (clk),
        .rst (rst),
        .bus (if_s)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: history of raw samples and conditioned levels
    // per button (0 = up, 1 = down), indexed by clock edge since reset.
    // ------------------------------------------------------------------
    logic raw_h [2][HMAX];
    logic lvl_h [2][HMAX];
    int   nh = 0;
    int   m_sel [2];
    bit   m_chg [2];

    function automatic logic sval(input int b, input int i);
        return (i >= 0) ? raw_h[b][i] : 1'b0;
    endfunction

    function automatic logic lval(input int b, input int i);
        return (i >= 0) ? lvl_h[b][i] : 1'b0;
    endfunction

    function automatic int next_sel(input int s, input bit wrap, input bit u,
                                    input bit d, input bit l, input int lv);
        if (l)
            return (lv > MAXV) ? MAXV : lv;
        if (u && !d)
            return wrap ? (s + 1) % (MAXV + 1) : ((s + 1 > MAXV) ? MAXV : s + 1);
        if (d && !u)
            return wrap ? (s + MAXV) % (MAXV + 1) : ((s == 0) ? 0 : s - 1);
        return s;
    endfunction

    initial begin
        m_sel[0] = 0; m_sel[1] = 0;
        m_chg[0] = 1'b0; m_chg[1] = 1'b0;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                nh = 0;
                for (int d = 0; d < 2; d++) begin
                    m_sel[d] = 0;
                    m_chg[d] = 1'b0;
                end
            end else begin
                bit   stp [2];
                logic cur [2];
                cur[0] = up;
                cur[1] = dn;
                if (nh >= HMAX) begin
                    $display("FAIL model_history: got %0d expected below %0d", nh, HMAX);
                    $fatal(1, "history overflow");
                end
                for (int b = 0; b < 2; b++) begin
                    logic lb;
                    logic nl;
                    bit   all_diff;
                    lb     = lval(b, nh - 1);
                    stp[b] = lb && !lval(b, nh - 2);
                    // s2 just before edge nh equals the raw sample from edge nh-2.
                    if (DEB) begin
                        all_diff = 1'b1;
                        for (int t = 0; t < DB; t++)
                            if (sval(b, nh - 2 - t) == lb) all_diff = 1'b0;
                        nl = all_diff ? ~lb : lb;
                    end else begin
                        nl = sval(b, nh - 1);
                    end
                    raw_h[b][nh] = cur[b];
                    lvl_h[b][nh] = nl;
                end
                nh++;
                for (int d = 0; d < 2; d++) begin
                    int nv;
                    nv = next_sel(m_sel[d], (d == 0), stp[0], stp[1], ld, int'(ldv));
                    m_chg[d] = (nv != m_sel[d]);
                    m_sel[d] = nv;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Compare process: every falling edge once enabled.
    // ------------------------------------------------------------------
    bit cmp_en  = 1'b0;
    int chg_cnt = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (if_w.changed) chg_cnt++;
            if (cmp_en) begin
                chk("w.sel",     int'(if_w.sel),     m_sel[0]);
                chk("w.changed", int'(if_w.changed), int'(m_chg[0]));
                chk("w.at_min",  int'(if_w.at_min),  int'(m_sel[0] == 0));
                chk("w.at_max",  int'(if_w.at_max),  int'(m_sel[0] == MAXV));
                chk("s.sel",     int'(if_s.sel),     m_sel[1]);
                chk("s.changed", int'(if_s.changed), int'(m_chg[1]));
                chk("s.at_min",  int'(if_s.at_min),  int'(m_sel[1] == 0));
                chk("s.at_max",  int'(if_s.at_max),  int'(m_sel[1] == MAXV));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #2;
        end
    endtask

    task automatic do_load(input int v);
        ld  = 1'b1;
        ldv = 3'(v);
        tick(1);
        ld  = 1'b0;
        tick(1);
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int c0;
        int v0;

        rst = 1'b1;
        tick(3);
        chk("rst.sel",     int'(if_w.sel),     0);
        chk("rst.at_min",  int'(if_w.at_min),  1);
        chk("rst.at_max",  int'(if_w.at_max),  0);
        chk("rst.changed", int'(if_w.changed), 0);
        rst    = 1'b0;
        cmp_en = 1'b1;
        tick(2);

        // Six clean up presses from reset.
        c0 = chg_cnt;
        for (int i = 0; i < 6; i++) begin
            up = 1'b1;
            tick(LAT + 2);
            up = 1'b0;
            tick(LAT + 2);
            chk("up6.w.sel", int'(if_w.sel), (i + 1) % 6);
            chk("up6.s.sel", int'(if_s.sel), (i + 1 > 5) ? 5 : i + 1);
            chk("up6.w.at_max", int'(if_w.at_max), (i == 4) ? 1 : 0);
        end
        chk("up6.changed_pulses", chg_cnt - c0, 6);

        // Seventh press: saturating instance stays at the top.
        up = 1'b1;
        tick(LAT + 2);
        up = 1'b0;
        tick(LAT + 2);
        chk("up7.s.sel", int'(if_s.sel), 5);
        chk("up7.w.sel", int'(if_w.sel), 1);

        // Down press at zero.
        rst = 1'b1;
        #1;
        chk("rst2.sel_immediate", int'(if_w.sel), 0);
        tick(1);
        rst = 1'b0;
        tick(2);
        dn = 1'b1;
        tick(LAT + 2);
        dn = 1'b0;
        tick(LAT + 2);
        chk("dn0.s.sel", int'(if_s.sel), 0);
        chk("dn0.w.sel", int'(if_w.sel), 5);

        // Both buttons rising together cancel.
        do_load(3);
        up = 1'b1;
        dn = 1'b1;
        tick(LAT + 3);
        chk("both.w.sel", int'(if_w.sel), 3);
        chk("both.s.sel", int'(if_s.sel), 3);
        up = 1'b0;
        dn = 1'b0;
        tick(LAT + 3);

        // Load with a concurrent up step; load wins and is clamped.
        do_load(2);
        up = 1'b1;
        tick(LAT);
        ld  = 1'b1;
        ldv = 3'd7;
        tick(1);
        ld  = 1'b0;
        chk("ld7.w.sel",     int'(if_w.sel),     5);
        chk("ld7.w.changed", int'(if_w.changed), 1);
        chk("ld7.s.sel",     int'(if_s.sel),     5);
        up = 1'b0;
        tick(2);
        ld  = 1'b1;
        ldv = 3'd5;
        tick(1);
        ld  = 1'b0;
        chk("ld5.w.changed", int'(if_w.changed), 0);
        chk("ld5.w.sel",     int'(if_w.sel),     5);
        tick(LAT + 2);

`ifdef INDEX_SELECTOR_DEBOUNCE_EN
        // Short glitch is filtered; a long press lands exactly LAT edges later.
        v0 = int'(if_w.sel);
        up = 1'b1;
        tick(2);
        up = 1'b0;
        tick(12);
        chk("glitch.w.sel", int'(if_w.sel), v0);
        up = 1'b1;
        tick(LAT);
        chk("deb.before", int'(if_w.sel), v0);
        tick(1);
        chk("deb.after", int'(if_w.sel), (v0 + 1) % 6);
        tick(4);
        up = 1'b0;
        tick(LAT + 4);
`else
        v0 = int'(if_w.sel);
        up = 1'b1;
        tick(LAT);
        chk("lat.before", int'(if_w.sel), v0);
        tick(1);
        chk("lat.after", int'(if_w.sel), (v0 + 1) % 6);
        up = 1'b0;
        tick(LAT + 2);
`endif

        // Reset during a held down button.
        do_load(4);
        dn = 1'b1;
        tick(1);
        rst = 1'b1;
        #1;
        chk("rstdn.w.sel",    int'(if_w.sel),    0);
        chk("rstdn.w.at_min", int'(if_w.at_min), 1);
        chk("rstdn.s.sel",    int'(if_s.sel),    0);
        tick(1);
        rst = 1'b0;
        tick(LAT + 10);
        chk("rstdn.w.wrap", int'(if_w.sel), 5);
        chk("rstdn.s.hold", int'(if_s.sel), 0);
        tick(20);
        chk("rstdn.w.once", int'(if_w.sel), 5);
        dn = 1'b0;
        tick(LAT + 2);

        // Randomized traffic.
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(5, 0) == 0) up = ~up;
            if ($urandom_range(5, 0) == 0) dn = ~dn;
            ld  = ($urandom_range(11, 0) == 0);
            ldv = 3'($urandom);
            if ($urandom_range(399, 0) == 0) begin
                rst = 1'b1;
                tick(1);
                rst = 1'b0;
            end else begin
                tick(1);
            end
        end
        up = 1'b0;
        dn = 1'b0;
        ld = 1'b0;
        tick(LAT + 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/index_selector.md
INDEX_SELECTOR -- requirements
Module: index_selector

Interface
- REQ-001: Parameter WIDTH, default 3: width of the selected index.
- REQ-002: Parameter MAX_VAL, default 5: highest legal index; SHALL satisfy 0 < MAX_VAL <= 2^WIDTH-1.
- REQ-003: Parameter WRAP, default 1: 1 = wrap-around at bounds, 0 = saturate at bounds.
- REQ-004: Parameter DB_CYCLES, default 4: debounce stability length in clocks; SHALL be >= 1.
- REQ-005: clk  input  1  single clock; all state updates on its rising edge.
- REQ-006: rst  input  1  asynchronous, active-high reset.
- REQ-007: btn_up  input  1  raw, asynchronous increment button.
- REQ-008: btn_down  input  1  raw, asynchronous decrement button.
- REQ-009: load  input  1  synchronous load strobe, sampled each clock.
- REQ-010: load_val  input  WIDTH  value to load when load=1.
- REQ-011: sel  output  WIDTH  current index, registered.
- REQ-012: changed  output  1  one-clock pulse when sel takes a new value.
- REQ-013: at_min  output  1  sel == 0, registered.
- REQ-014: at_max  output  1  sel == MAX_VAL, registered.

Function
- REQ-015: Each button SHALL pass through a 2-flop synchronizer (s1, s2) before any other use.
- REQ-016: A step event SHALL be the rising edge of the conditioned button level (level=1, previous level=0); held buttons SHALL produce exactly one step.
- REQ-017: Up step with sel < MAX_VAL SHALL set sel = sel+1 on the same clock edge.
- REQ-018: Down step with sel > 0 SHALL set sel = sel-1 on the same clock edge.
- REQ-019: Up step at sel == MAX_VAL: WRAP=1 -> sel = 0; WRAP=0 -> sel held.
- REQ-020: Down step at sel == 0: WRAP=1 -> sel = MAX_VAL; WRAP=0 -> sel held.
- REQ-021: Up and down steps in the same cycle SHALL cancel; sel held.
- REQ-022: load=1 SHALL take priority over steps; sel = load_val, clamped to MAX_VAL if load_val > MAX_VAL; steps in that cycle are discarded.
- REQ-023: sel SHALL never exceed MAX_VAL under any input sequence.
- REQ-024: changed SHALL be 1 for exactly the cycle after an edge where sel's value differed from its prior value; held/saturated steps and same-value loads SHALL NOT assert it.
- REQ-025: at_min/at_max SHALL be consistent with sel in every cycle (same-edge update).
- REQ-026: Latency without debounce: raw button high before edge N -> sel updates at edge N+2.

Reset
- REQ-027: rst=1 SHALL immediately force sel=0, changed=0, at_min=1, at_max=0, synchronizers, conditioned levels and debounce counters to 0.
- REQ-028: A button held high across reset release SHALL produce one step once its conditioned level rises from 0 after release (one step, not zero or two).
- REQ-029: Reset asserted mid-debounce SHALL discard the partial count.

Configuration
- REQ-030: Macro INDEX_SELECTOR_DEBOUNCE_EN defined: per button, a counter increments each cycle s2 differs from the conditioned level, clears when equal; on reaching DB_CYCLES the conditioned level takes s2 and the counter clears.
- REQ-031: With INDEX_SELECTOR_DEBOUNCE_EN, latency: raw high before edge N, stable -> conditioned level at edge N+1+DB_CYCLES, sel update at edge N+2+DB_CYCLES; glitches shorter than DB_CYCLES clocks SHALL produce no step.
- REQ-032: Macro undefined: conditioned level = s2; no counters instantiated; REQ-026 latency applies.

Verification
- REQ-033: Defaults, WRAP=1: 6 clean up presses from reset -> sel 1,2,3,4,5,0; changed pulses 6 times; at_max high only at 5.
- REQ-034: WRAP=0: down press at sel=0 -> sel stays 0, changed stays 0; 7 up presses -> sel saturates at 5.
- REQ-035: btn_up and btn_down rising in the same cycle at sel=3 -> sel stays 3, no changed pulse.
- REQ-036: load=1, load_val=7, concurrent up step -> sel=5 next edge, changed=1; repeat load_val=5 -> changed=0.
- REQ-037: Debounce enabled, DB_CYCLES=4: 2-clock glitch on btn_up -> no change; 10-clock press -> sel+1 exactly 6 edges after first sampled high.
- REQ-038: Assert rst for 1 clock while sel=4 and btn_down held -> sel=0 immediately; after release, debounce enabled: sel=5 (wrap) once, not repeated.
